elevator_scheduler: RTL and testbench

//   Collective (SCAN) scheduler for the 4-floor elevator.
//   - Latches hall calls (up/down buttons per floor) and car calls (cabin buttons) into sticky pending bits.
//   - Picks the direction of travel and sequences the car through the states idle, move and door-open.
//   - Drives motor and door controls plus the call lamps.
//   - Sits between the button inputs and the motor/door drivers.

---
 rtl/elevator_scheduler_pkg.sv | 38 +++
 rtl/elevator_request_latch.sv | 68 ++++++
 rtl/elevator_scheduler.sv | 191 +++++++++++++++++++
 tb/tb_elevator_scheduler.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/elevator_scheduler_pkg.sv
// Shared types and constants for the 4-floor SCAN elevator scheduler.
package elevator_scheduler_pkg;

    localparam int unsigned NUM_FLOORS = 4;
    localparam int unsigned FLOOR_W    = 2;
    localparam int unsigned TIMER_W    = 8;

    localparam logic [FLOOR_W-1:0] FLOOR_1 = 2'd0;
    localparam logic [FLOOR_W-1:0] FLOOR_2 = 2'd1;
    localparam logic [FLOOR_W-1:0] FLOOR_3 = 2'd2;
    localparam logic [FLOOR_W-1:0] FLOOR_4 = 2'd3;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        MOVE_UP   = 2'd1,
        MOVE_DOWN = 2'd2,
        DOOR_OPEN = 2'd3
    } state_e;

    // hall_up[i] is floor i going up; hall_down[i] is floor i+1 going down.
    typedef struct packed {
        logic [2:0] hall_up;
        logic [2:0] hall_down;
        logic [3:0] car;
    } calls_t;

    // Collapse all call types into one "something wants this floor" bit per floor.
    function automatic logic [NUM_FLOORS-1:0] floor_any(input calls_t c);
        logic [NUM_FLOORS-1:0] any;
        any          = c.car;
        any[FLOOR_1] = any[FLOOR_1] | c.hall_up[0];
        any[FLOOR_2] = any[FLOOR_2] | c.hall_up[1] | c.hall_down[0];
        any[FLOOR_3] = any[FLOOR_3] | c.hall_up[2] | c.hall_down[1];
        any[FLOOR_4] = any[FLOOR_4] | c.hall_down[2];
        return any;
    endfunction

endpackage

// File: rtl/elevator_request_latch.sv
// Sticky pending-call register with above/below/here flags relative to eval_floor.
module elevator_request_latch
    import elevator_scheduler_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic [2:0]         set_up,
    input  logic [2:0]         set_dn,
    input  logic [3:0]         set_car,
    input  logic [2:0]         clr_up,
    input  logic [2:0]         clr_dn,
    input  logic [3:0]         clr_car,
    input  logic [FLOOR_W-1:0] eval_floor,
    output logic [2:0]         pend_up,
    output logic [2:0]         pend_dn,
    output logic [3:0]         pend_car,
    output logic               above_c,
    output logic               below_c,
    output logic               here_c,
    output logic               car_here_c,
    output logic               up_here_c,
    output logic               down_here_c
);

    calls_t pend_q, pend_d, req_c;
    logic [NUM_FLOORS-1:0] any_c, up4_c, dn4_c;

    // Requests seen this cycle include same-cycle presses; clears win over sets.
    always_comb begin
        req_c.hall_up    = pend_q.hall_up   | set_up;
        req_c.hall_down  = pend_q.hall_down | set_dn;
        req_c.car        = pend_q.car       | set_car;
        pend_d.hall_up   = req_c.hall_up   & ~clr_up;
        pend_d.hall_down = req_c.hall_down & ~clr_dn;
        pend_d.car       = req_c.car       & ~clr_car;
    end

    // Pending-call storage.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pend_q <= '0;
        end else begin
            pend_q <= pend_d;
        end
    end

    // Position flags relative to the floor the FSM is deciding about.
    always_comb begin
        any_c   = floor_any(req_c);
        up4_c   = {1'b0, req_c.hall_up};
        dn4_c   = {req_c.hall_down, 1'b0};
        above_c = 1'b0;
        below_c = 1'b0;
        for (int i = 0; i < int'(NUM_FLOORS); i++) begin
            if (FLOOR_W'(i) > eval_floor) above_c = above_c | any_c[i];
            if (FLOOR_W'(i) < eval_floor) below_c = below_c | any_c[i];
        end
        here_c      = any_c[eval_floor];
        car_here_c  = req_c.car[eval_floor];
        up_here_c   = up4_c[eval_floor];
        down_here_c = dn4_c[eval_floor];
    end

    assign pend_up  = pend_q.hall_up;
    assign pend_dn  = pend_q.hall_down;
    assign pend_car = pend_q.car;

endmodule

// File: rtl/elevator_scheduler.sv
// Collective (SCAN) scheduler for a 4-floor elevator: FSM, travel/door timers, output decode.
// Optional feature: define DOOR_HOLD_EN to let door_hold freeze the door timer.
module elevator_scheduler
    import elevator_scheduler_pkg::*;
#(
    parameter int unsigned TRAVEL_CYCLES = 8,
    parameter int unsigned DOOR_CYCLES   = 6
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [2:0] hall_up,
    input  logic [2:0] hall_down,
    input  logic [3:0] car_call,
    input  logic       door_hold,
    output logic [1:0] current_floor,
    output logic       motor_up,
    output logic       motor_down,
    output logic       door_open,
    output logic       up_down_flag,
    output logic [2:0] up_lamp,
    output logic [2:0] down_lamp,
    output logic [3:0] car_lamp
);

    state_e               state_q, state_d;
    logic [FLOOR_W-1:0]   floor_q, floor_d, eval_floor_c;
    logic [TIMER_W-1:0]   tmr_q, tmr_d;
    logic                 flag_q, flag_d;
    logic                 motor_up_q, motor_up_d, motor_down_q, motor_down_d;
    logic                 door_open_q, door_open_d;
    logic                 arrive_c, moving_up_c;
    logic                 serve_c, serve_dir_c, further_c, opposite_c, press_here_c;
    logic [3:0]           clr_car_c, clr_up_c, clr_dn_c, up_in_c, dn_in_c;
    logic                 above_c, below_c, here_c, car_here_c, up_here_c, down_here_c;
    logic                 clr_spare_unused;
`ifndef DOOR_HOLD_EN
    logic                 door_hold_unused;
    assign door_hold_unused = door_hold;
`endif

    assign up_in_c          = {1'b0, hall_up};
    assign dn_in_c          = {hall_down, 1'b0};
    assign clr_spare_unused = clr_up_c[3] | clr_dn_c[0];

    elevator_request_latch u_req (
        .clk         (clk),
        .reset       (reset),
        .set_up      (hall_up),
        .set_dn      (hall_down),
        .set_car     (car_call),
        .clr_up      (clr_up_c[2:0]),
        .clr_dn      (clr_dn_c[3:1]),
        .clr_car     (clr_car_c),
        .eval_floor  (eval_floor_c),
        .pend_up     (up_lamp),
        .pend_dn     (down_lamp),
        .pend_car    (car_lamp),
        .above_c     (above_c),
        .below_c     (below_c),
        .here_c      (here_c),
        .car_here_c  (car_here_c),
        .up_here_c   (up_here_c),
        .down_here_c (down_here_c)
    );

    // Floor the car occupies after this edge; flags are evaluated against it.
    always_comb begin
        moving_up_c  = (state_q == MOVE_UP);
        arrive_c     = ((state_q == MOVE_UP) || (state_q == MOVE_DOWN)) &&
                       (tmr_q == TIMER_W'(TRAVEL_CYCLES - 1));
        eval_floor_c = floor_q;
        if (arrive_c) begin
            if (moving_up_c && (floor_q != FLOOR_4))         eval_floor_c = floor_q + 2'd1;
            else if (!moving_up_c && (floor_q != FLOOR_1))   eval_floor_c = floor_q - 2'd1;
        end
    end

    // Next-state, timers, call clears and output decode.
    always_comb begin
        state_d      = state_q;
        floor_d      = eval_floor_c;
        flag_d       = flag_q;
        tmr_d        = tmr_q;
        clr_car_c    = '0;
        clr_up_c     = '0;
        clr_dn_c     = '0;
        serve_c      = 1'b0;
        serve_dir_c  = flag_q;
        further_c    = 1'b0;
        opposite_c   = 1'b0;
        press_here_c = car_call[floor_q] | (flag_q ? up_in_c[floor_q] : dn_in_c[floor_q]);

        case (state_q)
            IDLE: begin
                tmr_d = '0;
                if (here_c) begin
                    serve_c     = 1'b1;
                    // A lone opposite-direction hall call turns the car round so it gets cleared.
                    serve_dir_c = (car_here_c || (flag_q ? up_here_c : down_here_c)) ? flag_q : ~flag_q;
                end else if (above_c && (flag_q || !below_c)) begin
                    state_d = MOVE_UP;
                    flag_d  = 1'b1;
                end else if (below_c) begin
                    state_d = MOVE_DOWN;
                    flag_d  = 1'b0;
                end
            end
            MOVE_UP, MOVE_DOWN: begin
                if (arrive_c) begin
                    tmr_d = '0;
                    if (car_here_c ||
                        (moving_up_c ? up_here_c : down_here_c) ||
                        !(moving_up_c ? above_c : below_c) ||
                        (moving_up_c ? (eval_floor_c == FLOOR_4) : (eval_floor_c == FLOOR_1))) begin
                        serve_c     = 1'b1;
                        serve_dir_c = moving_up_c;
                    end
                end else begin
                    tmr_d = tmr_q + TIMER_W'(1);
                end
            end
            DOOR_OPEN: begin
                clr_car_c[floor_q] = 1'b1;
                if (flag_q) clr_up_c[floor_q] = 1'b1;
                else        clr_dn_c[floor_q] = 1'b1;
                // The press cycle counts as the first cycle of the fresh open period.
                if (press_here_c) begin
                    tmr_d = TIMER_W'(1);
`ifdef DOOR_HOLD_EN
                end else if (door_hold) begin
                    tmr_d = tmr_q;
`endif
                end else if (tmr_q == TIMER_W'(DOOR_CYCLES - 1)) begin
                    state_d = IDLE;
                    tmr_d   = '0;
                end else begin
                    tmr_d = tmr_q + TIMER_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        if (serve_c) begin
            state_d   = DOOR_OPEN;
            tmr_d     = '0;
            clr_car_c[eval_floor_c] = 1'b1;
            if (serve_dir_c) clr_up_c[eval_floor_c] = 1'b1;
            else             clr_dn_c[eval_floor_c] = 1'b1;
            further_c  = serve_dir_c ? above_c : below_c;
            opposite_c = serve_dir_c ? below_c : above_c;
            flag_d     = serve_dir_c;
            if (!further_c) begin
                clr_up_c[eval_floor_c] = 1'b1;
                clr_dn_c[eval_floor_c] = 1'b1;
                if (opposite_c) flag_d = ~serve_dir_c;
            end
        end

        motor_up_d   = (state_d == MOVE_UP);
        motor_down_d = (state_d == MOVE_DOWN);
        door_open_d  = (state_d == DOOR_OPEN);
    end

    // State, position, timer and output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            floor_q      <= FLOOR_1;
            flag_q       <= 1'b1;
            tmr_q        <= '0;
            motor_up_q   <= 1'b0;
            motor_down_q <= 1'b0;
            door_open_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            floor_q      <= floor_d;
            flag_q       <= flag_d;
            tmr_q        <= tmr_d;
            motor_up_q   <= motor_up_d;
            motor_down_q <= motor_down_d;
            door_open_q  <= door_open_d;
        end
    end

    assign current_floor = floor_q;
    assign up_down_flag  = flag_q;
    assign motor_up      = motor_up_q;
    assign motor_down    = motor_down_q;
    assign door_open     = door_open_q;

endmodule

// File: tb/tb_elevator_scheduler.sv
// Scoreboard bench for elevator_scheduler: each stimulus pushes the door stops it should
// produce; the monitor pops one entry per completed door-open episode and compares.
module tb_elevator_scheduler;

    logic       clk = 1'b0;
    logic       reset;
    logic [2:0] hall_up, hall_down, up_lamp, down_lamp;
    logic [3:0] car_call, car_lamp;
    logic       door_hold;
    logic [1:0] current_floor;
    logic       motor_up, motor_down, door_open, up_down_flag;

    always #5 clk = ~clk;

    elevator_scheduler #(.TRAVEL_CYCLES(8), .DOOR_CYCLES(6)) dut (
        .clk           (clk),
        .reset         (reset),
        .hall_up       (hall_up),
        .hall_down     (hall_down),
        .car_call      (car_call),
        .door_hold     (door_hold),
        .current_floor (current_floor),
        .motor_up      (motor_up),
        .motor_down    (motor_down),
        .door_open     (door_open),
        .up_down_flag  (up_down_flag),
        .up_lamp       (up_lamp),
        .down_lamp     (down_lamp),
        .car_lamp      (car_lamp)
    );

    typedef struct {
        int flr;
        int door_len;
        int motor_len;
        int flag;
        int up;
        int dn;
        int car;
    } episode_t;

    episode_t exp_q[$];
    int n_cmp = 0;
    int n_err = 0;

`ifdef DOOR_HOLD_EN
    localparam int HOLD_DOOR_LEN = 16;
`else
    localparam int HOLD_DOOR_LEN = 6;
`endif

    task automatic check(input string tag, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    task automatic push_stop(input int flr, input int door_len, input int motor_len,
                             input int flag, input int up, input int dn, input int car);
        episode_t e;
        e.flr = flr; e.door_len = door_len; e.motor_len = motor_len;
        e.flag = flag; e.up = up; e.dn = dn; e.car = car;
        exp_q.push_back(e);
    endtask

    // Runs the car until every queued stop has been observed. Inputs driven before the
    // call are one-cycle pulses. Optional press/hold are injected at a door cycle number.
    task automatic drain(input int first_lamps, input int press_at, input logic [3:0] press_car,
                         input int hold_at, input int hold_len);
        int door_cnt = 0, motor_cnt = 0, idle_cnt = 0, flr = 0;
        int budget = 2000, hold_left = 0;
        bit prev_door = 1'b0, first = 1'b1;
        episode_t e;
        while (exp_q.size() > 0 && budget > 0) begin
            @(negedge clk);
            budget--;
            hall_up = '0; hall_down = '0; car_call = '0;
            if (first) begin
                check("first_lamps", int'({down_lamp, up_lamp, car_lamp}), first_lamps);
                first = 1'b0;
            end
            if (door_open) begin
                door_cnt++;
                flr = int'(current_floor);
            end else if (motor_up || motor_down) begin
                motor_cnt++;
            end else if (!prev_door) begin
                idle_cnt++;
            end
            if (prev_door && !door_open) begin
                e = exp_q.pop_front();
                check("stop_floor", flr, e.flr);
                check("door_len", door_cnt, e.door_len);
                check("motor_len", motor_cnt, e.motor_len);
                check("idle_gap", idle_cnt, 0);
                check("dir_flag", int'(up_down_flag), e.flag);
                check("up_lamp", int'(up_lamp), e.up);
                check("down_lamp", int'(down_lamp), e.dn);
                check("car_lamp", int'(car_lamp), e.car);
                door_cnt = 0; motor_cnt = 0; idle_cnt = 0;
            end
            prev_door = door_open;
            if (hold_left > 0) begin
                hold_left--;
                if (hold_left == 0) door_hold = 1'b0;
            end
            if (door_open && door_cnt == press_at + 1) car_call = press_car;
            if (door_open && door_cnt == hold_at) begin
                door_hold = 1'b1;
                hold_left = hold_len;
            end
        end
        if (exp_q.size() > 0) begin
            check("stop_timeout", exp_q.size(), 0);
            exp_q.delete();
        end
        door_hold = 1'b0;
    endtask

    initial begin
        reset = 1'b1; hall_up = '0; hall_down = '0; car_call = '0; door_hold = 1'b0;
        #1;
        check("rst_floor", int'(current_floor), 0);
        check("rst_flag", int'(up_down_flag), 1);
        check("rst_ctrl", int'({motor_up, motor_down, door_open}), 0);
        check("rst_lamps", int'({down_lamp, up_lamp, car_lamp}), 0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("idle_ctrl", int'({motor_up, motor_down, door_open}), 0);

        // Hall call at the current floor is served immediately and never latched.
        hall_up = 3'b001;
        push_stop(0, 6, 0, 1, 0, 0, 0);
        drain(0, -1, 4'b0000, -1, 0);

        // Up call on floor 1 and down call on floor 3: stop at 1 first, then 3.
        hall_up = 3'b010; hall_down = 3'b100;
        push_stop(1, 6, 8, 1, 0, 3'b100, 0);
        push_stop(3, 6, 16, 1, 0, 0, 0);
        drain(int'({3'b100, 3'b010, 4'b0000}), -1, 4'b0000, -1, 0);

        // Down to floor 1; re-pressing the car button at door count 4 restarts the door.
        car_call = 4'b0010;
        push_stop(1, 10, 16, 0, 0, 0, 0);
        drain(int'({6'b0, 4'b0010}), 4, 4'b0010, -1, 0);

        // Door-hold held for 10 cycles during the door-open period.
        car_call = 4'b0010;
        push_stop(1, HOLD_DOOR_LEN, 0, 0, 0, 0, 0);
        drain(0, -1, 4'b0000, 2, 10);

        // Reset asserted mid-move clears everything without a clock edge.
        car_call = 4'b1000;
        @(negedge clk);
        car_call = '0;
        repeat (10) @(negedge clk);
        check("moving_pre_rst", int'(motor_up), 1);
        #2 reset = 1'b1;
        #1;
        check("arst_floor", int'(current_floor), 0);
        check("arst_flag", int'(up_down_flag), 1);
        check("arst_ctrl", int'({motor_up, motor_down, door_open}), 0);
        check("arst_lamps", int'({down_lamp, up_lamp, car_lamp}), 0);
        @(negedge clk);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        check("post_rst_idle", int'({motor_up, motor_down, door_open}), 0);
        check("post_rst_lamps", int'(car_lamp), 0);

        // Car call to floor 2 from floor 0: 16 cycles of motor, 6 of door.
        car_call = 4'b0100;
        push_stop(2, 6, 16, 1, 0, 0, 0);
        drain(int'({6'b0, 4'b0100}), -1, 4'b0000, -1, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
